cmp_pair_feeder: RTL

Buffered operand-pair feeder sitting directly upstream of the 4-bit equality comparator (`eqcomparator4bit`, ports A, B, C). It accepts operand pairs over a valid/ready handshake into a small FIFO and drives the head pair onto the comparator inputs. It captures the comparator's equality result into a registered valid/ready output stage and keeps running pair and match counts. It turns the purely combinational comparator into a streaming, back-pressurable stage.

---
 rtl/cmp_pair_feeder.sv | 100 ++++++++++
 1 files changed

// File: rtl/cmp_pair_feeder.sv
// Buffered operand-pair feeder for the 4-bit equality comparator: a small FIFO
// drives the comparator inputs and a registered valid/ready stage captures results.
module cmp_pair_feeder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_eq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eq,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [LW-1:0]    fifo_level,
  output logic [CNT_W-1:0] pair_count,
  output logic [CNT_W-1:0] match_count
);

  typedef enum logic {S_IDLE, S_FULL} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop, empty;

  // in_ready looks only at registered occupancy so it never depends on out_ready
  assign in_ready  = (fifo_level != LW'(DEPTH));
  assign empty     = (fifo_level == '0);
  assign push      = in_valid && in_ready;
  assign out_valid = (state == S_FULL);
  assign pop       = !empty && (!out_valid || out_ready);
  assign cmp_a     = empty ? '0 : mem_a[rd_ptr];
  assign cmp_b     = empty ? '0 : mem_b[rd_ptr];

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (pop) state_nx = S_FULL;
      S_FULL:  if (out_ready && !pop) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Storage is left unreset; emptiness masks stale entries on cmp_a/cmp_b.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_eq      <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      pair_count  <= '0;
      match_count <= '0;
    end else if (pop) begin
      out_eq <= cmp_eq;
      out_a  <= cmp_a;
      out_b  <= cmp_b;
      if (pair_count != '1) pair_count <= pair_count + CNT_W'(1);
      if (cmp_eq && (match_count != '1)) match_count <= match_count + CNT_W'(1);
    end
  end

endmodule
